seq_pulse_gen: RTL and testbench
================================

# seq_pulse_gen

Pattern transmitter for the button-style sequence interface. On a start request it serialises a LEN-bit pattern, MSB first, into mutually exclusive one-cycle pulses on `p1` (bit = 1) and `p0` (bit = 0), with GAP idle cycles between pulses. It drives a sequence detector (e.g. the 1101 detector) in place of the board buttons, for self-test and for the bench. Busy and done status is provided for the controlling logic.

## Interface
- `LEN`, default 4: pattern length in bits. Legal range is LEN ≥ 1.
- `GAP`, default 2: idle cycles between consecutive pulses. Legal range is GAP ≥ 0.
- `clk`, input, 1 bit: the single clock. All state changes on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high. Dominates every other input.
- `start`, input, 1 bit: request to send. Sampled only in IDLE.
- `pattern`, input, LEN bits: bits to send. Latched on an accepted start. `pattern[LEN-1]` goes first.
- `p1`, output, 1 bit: one-cycle pulse meaning "1".
- `p0`, output, 1 bit: one-cycle pulse meaning "0".
- `busy`, output, 1 bit: high while the block is in EMIT or GAP.
- `done`, output, 1 bit: one-cycle pulse after the last bit has been sent.

## Operation
- **States:** IDLE, EMIT, GAP, DONE. All outputs are Moore outputs, decoded from registered state and datapath.
- **Reset:** state goes to IDLE. Shift register, bit counter and gap counter all clear to 0. `p1`, `p0`, `busy` and `done` are all 0.
- **IDLE:**
  - `start` = 1: latch `pattern` into the shift register, set bit counter = 0, go to EMIT.
  - Otherwise: stay in IDLE.
- **EMIT (exactly one cycle):**
  - `p1` = `shreg[LEN-1]`, `p0` = `~shreg[LEN-1]`.
  - On exit, shift the register left by 1.
  - If bit counter = LEN-1, go to DONE.
  - Else if GAP = 0, go to EMIT with bit counter +1.
  - Else clear the gap counter and go to GAP.
- **GAP:**
  - `p1` = `p0` = 0.
  - Gap counter increments each cycle.
  - When gap counter = GAP-1, go to EMIT with bit counter +1.
- **DONE:** `done` = 1 for one cycle, then go to IDLE. `start` is ignored in DONE.
- **Start while busy:** `start` in EMIT, GAP or DONE is ignored, not queued. Changes to `pattern` after acceptance have no effect.
- **Invariant:** `p1 & p0` = 0 in every cycle.
- **Counter widths:**
  - Bit counter is $clog2(LEN) bits, minimum 1.
  - Gap counter is $clog2(GAP) bits, minimum 1.
  - Neither counter wraps within a legal transaction.
- **Reset mid-operation:** the next edge returns to IDLE with all outputs 0. No `done` pulse. The partial pattern is discarded.

## Timing
- Let `start` be accepted at edge 0.
- EMIT occupies cycle 1 + k·(GAP+1) for k = 0 … LEN-1.
- `done` is high in cycle LEN·(GAP+1) − GAP + 1, i.e. one cycle after the last EMIT.
- `busy` is high from cycle 1 through the last EMIT cycle, inclusive.
- Earliest next accepted `start` is sampled in the cycle after DONE.
- Start-to-first-pulse latency is 1 cycle.
- With GAP = 0, pulses are back-to-back across LEN consecutive cycles.

## Structure
- **Shared package** (e.g. `seq_pkg`) holds:
  - the state enum (IDLE/EMIT/GAP/DONE, 2-bit encoding);
  - `SEQ_1101` = 4'b1101, the default detector pattern.
- The detector imports the same package constant.
- No sub-module is needed. The shift register, both counters and the state machine live in one module.

## Test plan
All scenarios use LEN = 4 and GAP = 2 unless stated otherwise.

- **Nominal send:** pattern = 4'b1101, `start` accepted at edge 0.
  - `p1` high in cycles 1 and 4; `p0` high in cycle 7; `p1` high in cycle 10.
  - `done` high in cycle 11.
  - `busy` high in cycles 1–10.
  - With the 1101 detector attached, `z` = 1 in cycle 10.
- **GAP = 0:** pattern = 4'b1010.
  - `p1`, `p0`, `p1`, `p0` in cycles 1–4.
  - `done` in cycle 5.
- **Ignored starts:**
  - `start` held high with a new pattern of 4'b0000 during cycles 2–11: output is unchanged from the nominal send.
  - A `start` held high through cycle 12 is accepted at that edge; its first pulse is in cycle 13.
- **Reset mid-operation:** `reset` asserted for cycle 5 of a nominal send.
  - From cycle 6 on, `p1`, `p0`, `busy` and `done` are all 0.
  - No `done` pulse is produced.
  - The next `start` behaves as nominal.
- **Reset priority:** `reset` and `start` high together.
  - Result is IDLE with all outputs 0.
- **Invariant:** check `p1 & p0` = 0 in every cycle across 1000 cycles of random start, pattern and reset stimulus.

Source files
------------

// File: rtl/seq_pulse_gen_pkg.sv
// Shared definitions for the button-style sequence interface: the transmitter
// state encoding and the default detector pattern.
package seq_pulse_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] SEQ_1101 = 4'b1101;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_pulse_gen.sv
// Serialises a LEN-bit pattern, MSB first, into one-cycle p1/p0 pulses
// separated by GAP idle cycles; busy/done report progress to the controller.
module seq_pulse_gen
  import seq_pulse_gen_pkg::*;
#(
  parameter int LEN = 4,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [LEN-1:0] pattern,
  output logic           p1,
  output logic           p0,
  output logic           busy,
  output logic           done
);

  localparam int BIT_W = cnt_width(LEN);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  seq_state_t       state;
  logic [LEN-1:0]   shreg;
  logic [LEN-1:0]   shreg_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Pattern as it stands after the EMIT-exit shift; with GAP = 0 its MSB is
  // the bit emitted in the very next cycle.
  assign shreg_next = shreg << 1;

  // Outputs are registered: each branch sets them to the values they must
  // carry in the state being entered, so they line up with the state register.
  // NOTE: every register here uses <= so all branches see pre-edge values;
  // a blocking write would leak a new value into later reads in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      p1      <= 1'b0;
      p0      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      p1   <= 1'b0;
      p0   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            shreg   <= pattern;
            bit_cnt <= '0;
            state   <= S_EMIT;
            p1      <= pattern[LEN-1];
            p0      <= ~pattern[LEN-1];
            busy    <= 1'b1;
          end
        end
        S_EMIT: begin
          shreg <= shreg_next;
          if (bit_cnt == LAST_BIT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (GAP == 0) begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= S_EMIT;
            p1      <= shreg_next[LEN-1];
            p0      <= ~shreg_next[LEN-1];
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == LAST_GAP) begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= S_EMIT;
            p1      <= shreg[LEN-1];
            p0      <= ~shreg[LEN-1];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pulse_gen.sv
// Directed bench for seq_pulse_gen: nominal send, ignored starts, resets,
// a GAP = 0 instance, and a random run checking that p1/p0 never overlap.
module tb_seq_pulse_gen;
  import seq_pulse_gen_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, start0;
  logic [3:0] pattern, pattern0;
  logic       p1, p0, busy, done;
  logic       q1, q0, busy0, done0;
  logic [2:0] hist = 3'b000;
  logic       z;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  seq_pulse_gen #(.LEN(4), .GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .p1(p1), .p0(p0), .busy(busy), .done(done)
  );

  seq_pulse_gen #(.LEN(4), .GAP(0)) dut_gap0 (
    .clk(clk), .reset(reset), .start(start0), .pattern(pattern0),
    .p1(q1), .p0(q0), .busy(busy0), .done(done0)
  );

  // Behavioural 1101 detector fed by the main instance's pulses (Mealy z).
  always @(posedge clk) if (p1 | p0) hist <= {hist[1:0], p1};
  assign z = (p1 | p0) && ({hist, p1} == SEQ_1101);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: outputs sampled on the falling edge that follows.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {p1,p0,busy,done} for pattern 1101, GAP 2, start accepted at edge 0.
  function automatic logic [3:0] nominal_exp(input int c);
    case (c)
      1, 4, 10:            return 4'b1010;
      7:                   return 4'b0110;
      2, 3, 5, 6, 8, 9:    return 4'b0010;
      11:                  return 4'b0001;
      default:             return 4'b0000;
    endcase
  endfunction

  // mode 0: nominal, 1: start held with pattern 0000 in cycles 2-12,
  // 2: reset during cycle 5. Entered and left just after a falling edge.
  task automatic run_main(input int mode);
    logic [3:0] exp;
    start   = 1'b1;
    pattern = 4'b1101;
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      exp = nominal_exp(c);
      if (mode == 1 && c == 13) exp = 4'b0110;
      if (mode == 1 && c == 14) exp = 4'b0010;
      if (mode == 2 && c >= 6)  exp = 4'b0000;
      check($sformatf("m%0d_c%0d", mode, c), {p1, p0, busy, done}, exp);
      if (mode == 0) check($sformatf("z_c%0d", c), z, (c == 10));
      start   = (mode == 1 && c >= 2 && c <= 12);
      pattern = (mode == 1 && c >= 2) ? 4'b0000 : 4'b1101;
      reset   = (mode == 2 && c == 5);
    end
    start = 1'b0;
    reset = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < 40 && !done; i++) next_cycle();
      check("drain_done", done, 1'b1);
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = 4'b0000;
    start0 = 1'b0; pattern0 = 4'b0000;
    next_cycle();
    next_cycle();
    check("reset_main", {p1, p0, busy, done}, 4'b0000);
    check("reset_gap0", {q1, q0, busy0, done0}, 4'b0000);

    // Reset and start together: reset wins, nothing is latched.
    start = 1'b1; pattern = 4'b1111;
    next_cycle();
    reset = 1'b0; start = 1'b0;
    check("rst_prio_0", {p1, p0, busy, done}, 4'b0000);
    next_cycle();
    check("rst_prio_1", {p1, p0, busy, done}, 4'b0000);

    run_main(0);
    run_main(1);
    run_main(2);
    run_main(0);

    // GAP = 0: pattern 1010 back to back, done in cycle 5.
    start0 = 1'b1; pattern0 = 4'b1010;
    for (int c = 1; c <= 6; c++) begin
      logic [3:0] exp;
      next_cycle();
      start0 = 1'b0;
      case (c)
        1, 3:    exp = 4'b1010;
        2, 4:    exp = 4'b0110;
        5:       exp = 4'b0001;
        default: exp = 4'b0000;
      endcase
      check($sformatf("gap0_c%0d", c), {q1, q0, busy0, done0}, exp);
    end

    for (int i = 0; i < 1000; i++) begin
      start    = 1'($urandom_range(0, 1));
      start0   = 1'($urandom_range(0, 1));
      pattern  = 4'($urandom);
      pattern0 = 4'($urandom);
      reset    = ($urandom_range(0, 15) == 0);
      next_cycle();
      check("excl_main", p1 & p0, 1'b0);
      check("excl_gap0", q1 & q0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
